wb_stage: RTL

- Writeback stage sitting directly upstream of the register file; the sole driver of its write port (valid, id, data).
- Accepts one retiring instruction at a time from the memory stage.
- For loads, waits for the data-cache response, then aligns and extends the data. For partial-word merge loads (LWL/LWR class), combines the data with the current destination value read back from the register file.
- Issues exactly one register write per accepted instruction that has a non-zero destination.

---
 rtl/wb_stage_pkg.sv | 23 ++
 rtl/wb_stage_if.sv | 32 +++
 rtl/wb_load_align.sv | 25 ++
 rtl/wb_stage.sv | 85 ++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared types for the writeback stage; the pc field exists only with WB_TRACE_EN.
package wb_stage_pkg;
   localparam int CREG_NUM = 32;
   typedef logic [31:0] word_t;
   typedef logic [$clog2(CREG_NUM)-1:0] creg_addr_t;
   typedef enum logic [1:0] {IDLE, WAIT_DATA, COMMIT} wb_state_t;
   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} load_size_t;
   typedef struct packed {
      logic       wen;
      creg_addr_t dst;
      logic       is_load;
      word_t      result;
      load_size_t size;
      logic       sext;
      logic [1:0] addr_lo;
      logic       merge;
      logic [1:0] rot;
      logic [3:0] strb;
`ifdef WB_TRACE_EN
      word_t      pc;
`endif
   } wb_req_t;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-stage request, data-cache response and regfile write port of the writeback stage.
interface wb_stage_if #(parameter int DATA_W = 32, parameter int REG_ID_W = 5) ();
   logic                in_valid;
   logic                in_ready;
   logic                in_wen;
   logic [REG_ID_W-1:0] in_dst;
   logic                in_is_load;
   logic [DATA_W-1:0]   in_result;
   logic [1:0]          in_size;
   logic                in_sext;
   logic [1:0]          in_addr_lo;
   logic                in_merge;
   logic [1:0]          in_rot;
   logic [3:0]          in_strb;
   logic [DATA_W-1:0]   in_pc;
   logic                dresp_valid;
   logic [DATA_W-1:0]   dresp_data;
   logic                rf_valid;
   logic [REG_ID_W-1:0] rf_id;
   logic [DATA_W-1:0]   rf_data;
   logic [DATA_W-1:0]   rf_original;
   modport slave (
      input  in_valid, in_wen, in_dst, in_is_load, in_result, in_size, in_sext, in_addr_lo,
             in_merge, in_rot, in_strb, in_pc, dresp_valid, dresp_data, rf_original,
      output in_ready, rf_valid, rf_id, rf_data
   );
   modport master (
      output in_valid, in_wen, in_dst, in_is_load, in_result, in_size, in_sext, in_addr_lo,
             in_merge, in_rot, in_strb, in_pc, dresp_valid, dresp_data, rf_original,
      input  in_ready, rf_valid, rf_id, rf_data
   );
endinterface

// File: rtl/wb_load_align.sv
// wb_load_align: load data extraction (size/sext/addr_lo) and rotate/strobe merge with the old register value.
module wb_load_align
   import wb_stage_pkg::*;
(
   input  word_t      data,
   input  word_t      orig,
   input  load_size_t size,
   input  logic       sext,
   input  logic [1:0] addr_lo,
   input  logic       merge,
   input  logic [1:0] rot,
   input  logic [3:0] strb,
   output word_t      result
);
   word_t sh, rotd, mrg;
   assign sh = data >> {addr_lo, 3'b000};
   // a rot of 0 shifts right by the full width, which contributes nothing
   assign rotd = (data << {rot, 3'b000}) | (data >> (6'd32 - {1'b0, rot, 3'b000}));
   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign mrg[8*i +: 8] = strb[i] ? rotd[8*i +: 8] : orig[8*i +: 8];
   end
   assign result = merge ? mrg :
                   size == BYTE ? {{24{sext & sh[7]}}, sh[7:0]} :
                   size == HALF ? {{16{sext & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage, sole driver of the regfile write port.
// Optional WB_TRACE_EN adds a per-retired-instruction trace port.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REG_ID_W = 5
) (
   input  logic              clk,
   input  logic              resetn,
   wb_stage_if.slave         bus,
   output logic              busy
`ifdef WB_TRACE_EN
   ,
   output logic              trace_valid,
   output logic [DATA_W-1:0] trace_pc,
   output logic              trace_wen,
   output logic [REG_ID_W-1:0] trace_id,
   output logic [DATA_W-1:0] trace_data
`endif
);
   wb_state_t state, state_n;
   wb_req_t req, in_req;
   word_t resp_q, aligned, result;
   logic [REG_ID_W-1:0] id_q;
   logic [DATA_W-1:0] data_q;
   logic accept, commit;
   always_comb begin
      in_req.wen     = bus.in_wen;
      in_req.dst     = bus.in_dst;
      in_req.is_load = bus.in_is_load;
      in_req.result  = bus.in_result;
      in_req.size    = load_size_t'(bus.in_size);
      in_req.sext    = bus.in_sext;
      in_req.addr_lo = bus.in_addr_lo;
      in_req.merge   = bus.in_merge;
      in_req.rot     = bus.in_rot;
      in_req.strb    = bus.in_strb;
`ifdef WB_TRACE_EN
      in_req.pc      = bus.in_pc;
`endif
   end
   assign commit       = state == COMMIT;
   assign bus.in_ready = state == IDLE || commit;
   assign accept       = bus.in_valid && bus.in_ready;
   assign busy         = state != IDLE;
   always_comb begin
      state_n = IDLE;
      state_n = state == WAIT_DATA ? (bus.dresp_valid ? COMMIT : WAIT_DATA) :
                accept ? (bus.in_is_load ? WAIT_DATA : COMMIT) : IDLE;
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         req    <= '0;
         resp_q <= '0;
         id_q   <= '0;
         data_q <= '0;
      end else begin
         if (accept) req <= in_req;
         if (state == WAIT_DATA && bus.dresp_valid) resp_q <= bus.dresp_data;
         if (commit) begin
            id_q   <= req.dst;
            data_q <= result;
         end
      end
   wb_load_align u_align (
      .data(resp_q), .orig(bus.rf_original), .size(req.size), .sext(req.sext),
      .addr_lo(req.addr_lo), .merge(req.merge), .rot(req.rot), .strb(req.strb), .result(aligned)
   );
   // rf_original arrives combinationally for rf_id, so the merge result is only valid during COMMIT
   assign result       = req.is_load ? aligned : req.result;
   assign bus.rf_valid = commit && req.wen && req.dst != '0;
   assign bus.rf_id    = commit ? req.dst : id_q;
   assign bus.rf_data  = commit ? result : data_q;
`ifdef WB_TRACE_EN
   assign trace_valid = commit;
   assign trace_pc    = req.pc;
   assign trace_wen   = req.wen;
   assign trace_id    = bus.rf_id;
   assign trace_data  = bus.rf_data;
`endif
endmodule
